// File: rtl/trigger_power_detector.sv
`default_nettype none
// ============================================================================
// Module      : trigger_power_detector
// Description : Sliding-window power detector with threshold trigger and holdoff
// Revision    : 1.0
// ============================================================================
module trigger_power_detector #(
    parameter int WINDOW_LOG2 = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [39:0]               dat_i,
    input  logic                      enable_i,
    input  logic [15:0]               threshold_i,
    input  logic [15:0]               holdoff_i,
    input  logic                      cnt_clr_i,
    output logic [12+WINDOW_LOG2-1:0] pwr_o,
    output logic                      trig_o,
    output logic [CNT_WIDTH-1:0]      trig_count_o,
    output logic                      holdoff_active_o
);

    localparam int c_DEPTH  = 1 << WINDOW_LOG2;
    localparam int c_SUM_W  = 12 + WINDOW_LOG2;
    localparam int c_NSAMP  = 8;

    // Reset asserts asynchronously but releases on a clock edge
    logic r_rst_meta;
    logic r_rst_n;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rst_meta <= 1'b0;
            r_rst_n    <= 1'b0;
        end else begin
            r_rst_meta <= 1'b1;
            r_rst_n    <= r_rst_meta;
        end
    end

    // S0: input register
    logic [39:0] r_dat;

    always_ff @(posedge aclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_dat <= '0;
        end else begin
            r_dat <= dat_i;
        end
    end

    // S1: per-sample squares; (-16)^2 = 256 is the only value needing bit 8
    logic [8:0] r_sq [c_NSAMP];

    for (genvar k = 0; k < c_NSAMP; k++) begin : g_square
        logic signed [4:0] w_s;
        logic signed [9:0] w_prod;

        assign w_s    = r_dat[5*k +: 5];
        assign w_prod = w_s * w_s;

        always_ff @(posedge aclk or negedge r_rst_n) begin
            if (!r_rst_n) begin
                r_sq[k] <= '0;
            end else begin
                r_sq[k] <= w_prod[8:0];
            end
        end
    end

    // S2: adder tree
    logic [9:0]  w_l1 [4];
    logic [10:0] w_l2 [2];
    logic [11:0] w_l3;
    logic [11:0] r_pwr_clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_l1[i] = {1'b0, r_sq[2*i]} + {1'b0, r_sq[2*i+1]};
        end
        for (int i = 0; i < 2; i++) begin
            w_l2[i] = {1'b0, w_l1[2*i]} + {1'b0, w_l1[2*i+1]};
        end
        w_l3 = {1'b0, w_l2[0]} + {1'b0, w_l2[1]};
    end

    always_ff @(posedge aclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_pwr_clk <= '0;
        end else begin
            r_pwr_clk <= w_l3;
        end
    end

    // S3: running window sum; history starts at zero so the sum is exact from reset
    logic [11:0]        r_hist [c_DEPTH];
    logic [c_SUM_W-1:0] r_sum;
    logic [c_SUM_W-1:0] w_new_ext;
    logic [c_SUM_W-1:0] w_old_ext;

    assign w_new_ext = c_SUM_W'(r_pwr_clk);
    assign w_old_ext = c_SUM_W'(r_hist[c_DEPTH-1]);

    always_ff @(posedge aclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_hist[i] <= '0;
            end
            r_sum <= '0;
        end else begin
            r_hist[0] <= r_pwr_clk;
            for (int i = 1; i < c_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
            r_sum <= r_sum + w_new_ext - w_old_ext;
        end
    end

    assign pwr_o = r_sum;

    // S4: threshold compare, trigger and holdoff
    logic        w_fire;
    logic        w_trig_next;
    logic [15:0] w_hold_next;
    logic        r_trig;
    logic [15:0] r_hold;
    logic        r_hold_active;

    assign w_fire = (17'(r_sum) > 17'(threshold_i));

    always_comb begin
        w_trig_next = 1'b0;
        w_hold_next = r_hold;
        if (!enable_i) begin
            w_hold_next = '0;
        end else if (w_fire && (r_hold == 16'd0)) begin
            w_trig_next = 1'b1;
            w_hold_next = holdoff_i;
        end else if (r_hold != 16'd0) begin
            w_hold_next = r_hold - 16'd1;
        end
    end

    always_ff @(posedge aclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_trig        <= 1'b0;
            r_hold        <= '0;
            r_hold_active <= 1'b0;
        end else begin
            r_trig        <= w_trig_next;
            r_hold        <= w_hold_next;
            r_hold_active <= (w_hold_next != 16'd0);
        end
    end

    assign trig_o           = r_trig;
    assign holdoff_active_o = r_hold_active;

    // Counter moves on the same edge that raises trig_o; clear wins over increment
    logic [CNT_WIDTH-1:0] r_cnt;

    always_ff @(posedge aclk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            r_cnt <= '0;
        end else if (cnt_clr_i) begin
            r_cnt <= '0;
        end else if (w_trig_next && (r_cnt != {CNT_WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    assign trig_count_o = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_trigger_power_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_trigger_power_detector
// Description : Directed self-checking bench for trigger_power_detector
// Revision    : 1.0
// ============================================================================
module tb_trigger_power_detector;

    localparam int WINDOW_LOG2 = 2;
    localparam int CNT_WIDTH   = 4;

    localparam logic [39:0] c_ALL15  = {8{5'b01111}};
    localparam logic [39:0] c_ALLM16 = {8{5'b10000}};
    localparam logic [39:0] c_ZERO   = 40'd0;

    logic                      aclk = 1'b0;
    logic                      aresetn = 1'b1;
    logic [39:0]               dat_i = '0;
    logic                      enable_i = 1'b0;
    logic [15:0]               threshold_i = 16'hFFFF;
    logic [15:0]               holdoff_i = 16'd0;
    logic                      cnt_clr_i = 1'b0;
    logic [12+WINDOW_LOG2-1:0] pwr_o;
    logic                      trig_o;
    logic [CNT_WIDTH-1:0]      trig_count_o;
    logic                      holdoff_active_o;

    int n_tests = 0;
    int n_fail  = 0;

    trigger_power_detector #(
        .WINDOW_LOG2 (WINDOW_LOG2),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .dat_i            (dat_i),
        .enable_i         (enable_i),
        .threshold_i      (threshold_i),
        .holdoff_i        (holdoff_i),
        .cnt_clr_i        (cnt_clr_i),
        .pwr_o            (pwr_o),
        .trig_o           (trig_o),
        .trig_count_o     (trig_count_o),
        .holdoff_active_o (holdoff_active_o)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".pwr"},  32'(pwr_o), 32'd0);
        chk({tag, ".trig"}, 32'(trig_o), 32'd0);
        chk({tag, ".cnt"},  32'(trig_count_o), 32'd0);
        chk({tag, ".hact"}, 32'(holdoff_active_o), 32'd0);
    endtask

    initial begin
        bit seen;

        // Reset values with random data
        #2 aresetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dat_i = 40'({$urandom(), $urandom()});
            tick();
        end
        chk_all_zero("reset");
        dat_i   = c_ZERO;
        aresetn = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk_all_zero("post_release");

        // Single all-15 clock: 8*225 = 1800 for 4 clocks starting N+3
        dat_i = c_ALL15;
        tick();
        dat_i = c_ZERO;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("impulse_pwr", 32'(pwr_o), 32'd1800);
        end
        tick();
        chk("impulse_end", 32'(pwr_o), 32'd0);
        chk("impulse_notrig", 32'(trig_o), 32'd0);

        // Constant -16: ramp 2048, 4096, 6144, 8192, 8192
        dat_i = c_ALLM16;
        tick();
        tick();
        tick();
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("ramp_pwr", 32'(pwr_o), 32'(2048 * ((i < 4) ? i : 4)));
        end

        // Constant all-15: window 7200
        dat_i = c_ALL15;
        for (int i = 0; i < 8; i++) tick();
        chk("w7200_pwr", 32'(pwr_o), 32'd7200);
        enable_i    = 1'b1;
        threshold_i = 16'd7200;
        holdoff_i   = 16'd0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("thr_equal_notrig", 32'(trig_o), 32'd0);
        end
        chk("thr_equal_cnt", 32'(trig_count_o), 32'd0);

        // Threshold one below: trigger every clock, counter saturates at 15
        threshold_i = 16'd7199;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("thr_below_trig", 32'(trig_o), 32'd1);
            chk("thr_below_hact", 32'(holdoff_active_o), 32'd0);
        end
        chk("cnt_saturate", 32'(trig_count_o), 32'd15);

        // Clear on a trigger cycle wins
        cnt_clr_i = 1'b1;
        tick();
        chk("clr_on_trig_trig", 32'(trig_o), 32'd1);
        chk("clr_on_trig_cnt", 32'(trig_count_o), 32'd0);
        cnt_clr_i = 1'b0;
        tick();
        chk("cnt_after_clr", 32'(trig_count_o), 32'd1);

        // Holdoff 10 with constant -16 input
        enable_i    = 1'b0;
        cnt_clr_i   = 1'b1;
        threshold_i = 16'd100;
        holdoff_i   = 16'd10;
        dat_i       = c_ALLM16;
        for (int i = 0; i < 8; i++) tick();
        cnt_clr_i = 1'b0;
        chk("hold_pre_cnt", 32'(trig_count_o), 32'd0);
        chk("hold_pre_pwr", 32'(pwr_o), 32'd8192);
        chk("hold_pre_hact", 32'(holdoff_active_o), 32'd0);
        enable_i = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick();
            chk("hold_pulse_trig", 32'(trig_o), 32'd1);
            chk("hold_pulse_hact", 32'(holdoff_active_o), 32'd1);
            chk("hold_pulse_cnt", 32'(trig_count_o), 32'(p + 1));
            if (p < 4) begin
                for (int k = 1; k <= 10; k++) begin
                    tick();
                    chk("hold_gap_trig", 32'(trig_o), 32'd0);
                    chk("hold_gap_hact", 32'(holdoff_active_o), (k < 10) ? 32'd1 : 32'd0);
                end
            end
        end
        chk("hold_cnt5", 32'(trig_count_o), 32'd5);

        // Disable mid-holdoff, then re-enable with fire true
        tick();
        tick();
        chk("mid_hold_hact", 32'(holdoff_active_o), 32'd1);
        enable_i = 1'b0;
        tick();
        chk("disable_hact", 32'(holdoff_active_o), 32'd0);
        chk("disable_trig", 32'(trig_o), 32'd0);
        enable_i = 1'b1;
        tick();
        chk("reenable_trig", 32'(trig_o), 32'd1);
        chk("reenable_cnt", 32'(trig_count_o), 32'd6);
        chk("reenable_hact", 32'(holdoff_active_o), 32'd1);

        // Asynchronous reset mid-run
        holdoff_i = 16'd0;
        tick();
        aresetn = 1'b0;
        #1;
        chk_all_zero("async_reset");
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_reset_notrig", 32'(trig_o), 32'd0);
        end
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            tick();
            if (trig_o === 1'b1) seen = 1'b1;
        end
        chk("post_reset_trig_resumes", 32'(seen), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trigger_power_detector.md
Name: trigger_power_detector

Overview:
- Consumes the 40-bit AGC-scaled 5-bit sample stream from the pre-trigger filter chain: 8 samples per aclk.
- Computes instantaneous power (sum of squares) and a sliding-window power sum over 2^WINDOW_LOG2 clocks.
- Compares the window sum to a programmable threshold and issues single-cycle trigger pulses with programmable holdoff.
- Sits directly downstream of the filter/AGC chain, ahead of trigger combining logic.

Parameters:
WINDOW_LOG2, 2, log2 of window length in clocks; legal range 0..3 (window = 1, 2, 4 or 8 clocks)
CNT_WIDTH, 32, width of saturating trigger counter

Ports:
aclk  input  1  processing clock; all logic in this domain
aresetn  input  1  asynchronous active-low reset
dat_i  input  40  8 samples, sample k at [5k+4:5k], 5-bit two's complement (-16..15), sample 0 earliest
enable_i  input  1  trigger enable; power path runs regardless
threshold_i  input  16  unsigned window-power threshold; trigger when sum strictly greater
holdoff_i  input  16  clocks of trigger suppression after each trigger
cnt_clr_i  input  1  synchronous clear of trig_count_o
pwr_o  output  12+WINDOW_LOG2  current window power sum, unsigned
trig_o  output  1  one-cycle trigger pulse
trig_count_o  output  CNT_WIDTH  number of triggers issued, saturating
holdoff_active_o  output  1  high while holdoff counter nonzero

Behaviour:
- Reset (async assert, sync release inside block): all pipeline registers, window history, pwr_o, trig_o, holdoff counter, trig_count_o = 0.
- Pipeline, dat_i sampled at edge N:
  - S0 (N): input register.
  - S1 (N+1): 8 squares, each 9-bit unsigned (max 256).
  - S2 (N+2): adder tree, 12-bit unsigned (max 2048).
  - S3 (N+3): window sum updated; pwr_o valid.
  - S4 (N+4): trig_o.
- Window sum: running sum = previous + newest - oldest, using a 2^WINDOW_LOG2-deep shift register of per-clock powers. History is reset to zero, so sums are exact from reset with no fill period. Width 12+WINDOW_LOG2 never overflows: max 2048 * 2^WINDOW_LOG2 fits. WINDOW_LOG2 = 0 → pwr_o = per-clock power.
- Compare: fire = (zero-extended pwr) > threshold_i, using pwr at S3. threshold_i and holdoff_i are sampled live each cycle; no shadowing.
- Trigger logic:
  - trig_o = 1 for one cycle when fire && enable_i && holdoff counter == 0.
  - On the same edge, the holdoff counter loads holdoff_i.
  - Otherwise a nonzero counter decrements by 1.
  - With sustained fire and holdoff H: triggers at T, T+H+1, T+2(H+1), ... H = 0 → trigger every clock.
- enable_i low: trig_o forced 0; holdoff counter cleared to 0 on the next edge. Power path unaffected.
- holdoff_active_o = (counter != 0), registered alongside the counter.
- trig_count_o:
  - Increments on each trig_o pulse; saturates at all-ones.
  - cnt_clr_i has priority: if asserted in the same cycle as a trigger, the result is 0.
- Reset mid-operation: everything returns to zero immediately (async); no trigger for at least 4 clocks after release.

Test Plan:
- Reset values: hold aresetn low with random dat_i → pwr_o = 0, trig_o = 0, trig_count_o = 0, holdoff_active_o = 0. Release and drive dat_i = 0 → outputs stay 0.
- Latency/window (WINDOW_LOG2 = 2): from reset, one clock with all samples = 15, then zeros.
  - pwr_o = 1800 on the 4 clocks starting N+3, then 0.
  - With all samples = -16 held constant: pwr_o ramps 2048, 4096, 6144, 8192, then stays 8192.
- Threshold boundary: constant all-15 input (window 7200).
  - threshold = 7200 → no trigger.
  - threshold = 7199, holdoff = 0, enable = 1 → trig_o high every clock once the window is full.
- Holdoff: threshold = 100, holdoff = 10, constant all-(-16) input → trig_o pulses exactly 11 clocks apart; holdoff_active_o high for 10 clocks between pulses; trig_count_o = 5 after 5 pulses.
- Enable/clear interaction:
  - Deassert enable mid-holdoff → holdoff_active_o drops next clock.
  - Re-enable with fire true → trigger on the first enabled cycle.
  - Assert cnt_clr_i on a trigger cycle → trig_count_o = 0.
- Saturation and async reset: CNT_WIDTH = 4, holdoff = 0, sustained fire → trig_count_o sticks at 15. Assert aresetn low mid-run → all outputs 0 asynchronously, before the next aclk edge.
